// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Purpose:
//   Multi-cycle adder sequencer. It adds two WIDTH-bit operands with a single
//   4-bit fullAdder2_4bit slice. One nibble is processed per cycle, LSB nibble
//   first. A carry register chains each slice into the next. A start/busy/done
//   handshake lets the caller issue wide adds without extra adder hardware.
//
// Optional feature (compile-time macro SERIAL_ADDER_SUB_EN):
//   When the macro is defined, the block gains a 'sub' input. An accepted start
//   with sub=1 computes a - b modulo 2^WIDTH. In that case cout=1 means no
//   borrow occurred.
//
// Ports:
//   clk   in   1      system clock, rising edge
//   rst   in   1      asynchronous, active-high reset
//   start in   1      request a new add; only sampled in IDLE
//   a, b  in   WIDTH  operands, captured on an accepted start
//   cin   in   1      carry into nibble 0, captured on an accepted start
//   sub   in   1      (SERIAL_ADDER_SUB_EN only) subtract select
//   busy  out  1      high in RUN and DONE
//   done  out  1      one-cycle pulse; sum/cout are final
//   sum   out  WIDTH  result register
//   cout  out  1      carry out of the most significant nibble
// -----------------------------------------------------------------------------

// 4-bit ripple-carry slice built from gate-level full adders.
module fullAdder2_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_reg, b_reg, sum_q;
  logic             carry, cout_q, sub_reg;
  logic [IDX_W-1:0] idx;

  logic [3:0] slice_a, slice_b, slice_s;
  logic       slice_cout;
  logic       last_slice;
  logic       init_carry;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1, so the carry-in is forced high and cin ignored.
  assign init_carry = sub ? 1'b1 : cin;
`else
  assign init_carry = cin;
  assign sub_reg    = 1'b0;
`endif

  // Nibble selection. {idx, 2'b00} is 4*idx without a multiplier.
  assign slice_a    = a_reg[{idx, 2'b00} +: 4];
  assign slice_b    = b_reg[{idx, 2'b00} +: 4] ^ {4{sub_reg}};
  assign last_slice = (idx == LAST_IDX);

  fullAdder2_4bit u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)      state_nxt = RUN;
      RUN:     if (last_slice) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Datapath. Everything is cleared on reset so that no partial result survives an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      a_reg  <= '0;
      b_reg  <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          a_reg <= a;
          b_reg <= b;
          carry <= init_carry;
          idx   <= '0;
          sum_q <= '0;
        end
        RUN: begin
          sum_q[{idx, 2'b00} +: 4] <= slice_s;
          carry                    <= slice_cout;
          if (last_slice) cout_q <= slice_cout;
          else            idx    <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_SUB_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         sub_reg <= 1'b0;
    else if (state == IDLE && start) sub_reg <= sub;
  end
`endif

  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Directed testbench for serial_adder_ctrl with WIDTH=16. All expected values
// are hand-computed constants. Subtract vectors are compiled only when
// SERIAL_ADDER_SUB_EN is defined.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        busy, done, cout;
  logic [15:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
  logic        sub;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Step clock edges (sampling 1ns after each edge) until done is seen or
  // the budget runs out. The result is budget+1 on timeout.
  task automatic wait_done(input int budget, output int edges);
    edges = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      edges++;
      if (done) return;
    end
    edges = budget + 1;
  endtask

  // Runs one transaction. The caller must be 1ns after a rising edge and in IDLE.
  task automatic run_add(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic vs,
                         input logic [15:0] es, input logic ec);
    int n;
    a = va; b = vb; cin = vc;
`ifdef SERIAL_ADDER_SUB_EN
    sub = vs;
`else
    if (vs) $display("note: %s requests subtract in add-only build", tag);
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'h0; b = 16'h0; cin = 1'b0;   // operands may change after acceptance
    check({tag, ".busy"}, busy, 1);
    wait_done(8, n);
    check({tag, ".lat"}, n, 4);
    check({tag, ".sum"}, sum, es);
    check({tag, ".cout"}, cout, ec);
    @(posedge clk); #1;
    check({tag, ".idle_busy"}, busy, 0);
    check({tag, ".idle_done"}, done, 0);
  endtask

  initial begin
    int n;
    int dones;
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic [15:0] vs [3];
    logic        vc [3];

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    #3;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.sum", sum, 0);
    check("rst.cout", cout, 0);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // Basic adds and full-carry ripple.
    run_add("add1", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0);
    run_add("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_add("cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);

    // start is held during RUN and DONE and must be ignored there.
    a = 16'h00F0; b = 16'h0010; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'hAAAA;
    check("hold.busy", busy, 1);
    dones = 0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (i == 4) begin
        check("hold.done_at4", done, 1);
        check("hold.sum", sum, 16'h0100);
        check("hold.cout", cout, 0);
      end
    end
    check("hold.idle", busy, 0);
    check("hold.ndone", dones, 1);
    start = 1'b0;
    @(posedge clk); #1;
    check("hold.noaccept", busy, 0);
    check("hold.keep_sum", sum, 16'h0100);

    // Asynchronous reset after the second RUN slice.
    a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort.partial", sum, 16'h0045);
    #1 rst = 1'b1;
    #1;
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.sum", sum, 0);
    check("abort.cout", cout, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run_add("post_rst", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);

    // Back-to-back with start held high: one acceptance every 6 cycles.
    va[0] = 16'h0001; vb[0] = 16'h0002; vs[0] = 16'h0003; vc[0] = 1'b0;
    va[1] = 16'h7FFF; vb[1] = 16'h0001; vs[1] = 16'h8000; vc[1] = 1'b0;
    va[2] = 16'hABCD; vb[2] = 16'h5433; vs[2] = 16'h0000; vc[2] = 1'b1;
    a = va[0]; b = vb[0]; cin = 1'b0; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done(10, n);
      check($sformatf("b2b%0d.gap", k), n, (k == 0) ? 5 : 6);
      check($sformatf("b2b%0d.sum", k), sum, vs[k]);
      check($sformatf("b2b%0d.cout", k), cout, vc[k]);
      if (k < 2) begin
        a = va[k+1]; b = vb[k+1];
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b.idle", busy, 0);

`ifdef SERIAL_ADDER_SUB_EN
    run_add("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    run_add("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    run_add("sub_off", 16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
